sa_fifo_ctrl_16x128: RTL

SA_FIFO_CTRL_16X128 -- requirements
Module: sa_fifo_ctrl_16x128

---
 rtl/sa_fifo_ctrl_16x128.sv | 117 +++++++++++
 1 files changed

// File: rtl/sa_fifo_ctrl_16x128.sv
// FIFO controller for an external 16x128 RAM with one-cycle registered read,
// fronted by a two-entry (head + skid) output buffer so reads stream at full rate.
module sa_fifo_ctrl_16x128 #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [3:0]       ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [3:0]       ram_ra,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [4:0]       fifo_cnt
);

    localparam logic [4:0] RAM_FULL = 5'(DEPTH);

    logic [3:0]       wr_ptr_q, wr_ptr_d;
    logic [3:0]       rd_ptr_q, rd_ptr_d;
    logic [4:0]       ram_cnt_q, ram_cnt_d;
    logic             inflt_q, inflt_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [1:0] occ_after_pop;
    logic [2:0] pending;

    // NOTE: ready is masked by rst so it reads 0 asynchronously during reset;
    // it never depends on rd_prdy.
    assign wr_prdy = !rst && (ram_cnt_q != RAM_FULL);
    assign push    = wr_pvld && wr_prdy;
    assign rd_pvld = (occ_q != 2'd0);
    assign rd_pd   = head_q;
    assign pop     = rd_pvld && rd_prdy;

    // Entries the buffer will hold once the in-flight read lands and any pop leaves.
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign pending       = {1'b0, occ_after_pop} + {2'b00, inflt_q};
    assign issue         = (ram_cnt_q != 5'd0) && (pending < 3'd2);

    assign ram_we   = push;
    assign ram_wa   = wr_ptr_q;
    assign ram_di   = wr_pd;
    assign ram_re   = issue;
    assign ram_ra   = rd_ptr_q;
    assign fifo_cnt = ram_cnt_q + {4'b0000, inflt_q} + {3'b000, occ_q};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        inflt_d   = issue;
        occ_d     = pending[1:0];
        head_d    = head_q;
        skid_d    = skid_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 4'd1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 4'd1;
        end

        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 5'd1;
            2'b01:   ram_cnt_d = ram_cnt_q - 5'd1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        if (pop && (occ_q == 2'd2)) begin
            head_d = skid_q;
        end
        // Returning RAM data fills the first free slot left after the pop.
        if (inflt_q) begin
            if (occ_after_pop == 2'd0) begin
                head_d = ram_dout;
            end else begin
                skid_d = ram_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= 4'd0;
            rd_ptr_q  <= 4'd0;
            ram_cnt_q <= 5'd0;
            inflt_q   <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            inflt_q   <= inflt_d;
            occ_q     <= occ_d;
        end
    end

    // NOTE: payload registers carry no reset; occ_q alone says whether they hold data.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

endmodule
